spi_reg_bridge: RTL
===================

Name: spi_reg_bridge

Overview:
- Byte-protocol layer between the SPI byte slave and an internal parallel register bus.
- Consumes the slave's received-byte strobe and data, and decodes a command byte followed by a data burst with address auto-increment.
- Issues single-cycle register read and write strobes.
- Supplies the next transmit byte on the slave's dataToSend input.

Parameters:
- STATUS_BYTE, 8'hA5: byte returned on MISO during the command byte.
- WRITE_FILL, 8'h00: byte returned on MISO during write-burst data bytes.

Ports:
- clk  in  1  system clock; same clock as the SPI slave.
- rst_n  in  1  asynchronous, active-low reset.
- ssel  in  1  SPI chip select, active low; same net as the slave's ssel.
- byte_received  in  1  one-cycle strobe from the slave: a byte is complete.
- received_data  in  8  byte from the slave; valid while byte_received=1.
- data_needed  in  1  slave is loading its transmit buffer (bitcnt==0); informational only.
- data_to_send  out  8  next transmit byte to the slave.
- reg_addr  out  7  register address.
- reg_wdata  out  8  register write data.
- reg_we  out  1  single-cycle write strobe.
- reg_re  out  1  single-cycle read strobe.
- reg_rdata  in  8  read data; valid exactly 1 clk after reg_re.
- frame_active  out  1  a frame is in progress (state != IDLE).
- byte_count  out  8  bytes received in the current frame; saturates at 255.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; data_to_send=STATUS_BYTE; reg_addr=0, reg_wdata=0; reg_we=0, reg_re=0; byte_count=0; frame_active=0.
- Command format, first byte of a frame: bit7=rw (1=read, 0=write); bits6:0=start address.
- States and transitions:
  - IDLE: entered on reset or whenever ssel=1, one clk after ssel is sampled high. ssel=0 → CMD. data_to_send=STATUS_BYTE.
  - CMD: wait for byte_received. Latch addr=received_data[6:0]. rw=0 → WRITE; rw=1 → RD_ISSUE.
  - WRITE: on each byte_received, next clk drives reg_we=1 for exactly 1 clk with reg_addr=addr and reg_wdata=received_data. addr increments on the following clk. data_to_send=WRITE_FILL.
  - RD_ISSUE: reg_re=1 with reg_addr=addr for 1 clk → RD_CAPTURE.
  - RD_CAPTURE: data_to_send<=reg_rdata; addr<=addr+1 → READ.
  - READ: each byte_received → RD_ISSUE. The byte sent is always the one fetched after the previous byte completed.
- Read latency: data_to_send is updated 3 clks after byte_received (issue, capture, register). The slave loads data_to_send while bitcnt==0. Requirement: the first SCK rising edge of the next byte is ≥4 clk after the byte_received pulse (SCK half-period ≥4 clk is sufficient).
- The first read data byte appears on MISO in frame byte 2. The command byte always returns STATUS_BYTE.
- Address: 7-bit, wraps 7'h7F → 7'h00 in both read and write bursts.
- byte_count: increments on every accepted byte_received; saturates at 8'hFF; clears in IDLE.
- ssel high mid-frame: abort. The state goes to IDLE next clk and no new strobes are issued. A reg_we or reg_re already scheduled for this clk still completes (1 clk). A pending RD_CAPTURE is dropped and data_to_send returns to STATUS_BYTE.
- byte_received in a cycle where ssel=1 is ignored. Requirement: ssel is held low ≥2 clk after the last SCK rising edge.
- byte_received while the machine is in RD_ISSUE or RD_CAPTURE is a protocol overrun. The byte is ignored for read purposes, byte_count still increments, and no extra strobe is issued.
- reg_we and reg_re are never both 1. Each is a 1-clk pulse.

Test Plan:
- Write burst: ssel=0; bytes 0x05,0x11,0x22,0x33 → reg_we pulses at addr 5/6/7 with data 0x11/0x22/0x33; MISO bytes A5,00,00,00; byte_count=4.
- Read burst: register model returns addr^0xFF; bytes 0x82 then 3 dummies → reg_re at addr 2,3,4,5; MISO bytes A5,FD,FC,FB.
- Wrap: write command 0x7F then 2 data bytes → writes to addr 7F then 00.
- Abort: read frame with ssel raised 1 clk after the command byte's byte_received → at most one reg_re; IDLE next clk; data_to_send=A5; frame_active=0.
- Reset mid-write: rst_n low during WRITE → all outputs at reset values immediately; the next frame decodes its first byte as a command.
- Command-only frame: byte 0x10, then ssel high → no reg_we; byte_count=1 until IDLE, then 0.

Source files
------------

// File: rtl/spi_reg_bridge_if.sv
// Parallel register bus between the SPI byte bridge and the register file.
// The bridge is master; the register file answers reg_rdata 1 clk after reg_re.
interface spi_reg_bridge_if;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI byte stream to register bus: command byte {rw, addr[6:0]}
// followed by an auto-incrementing read or write burst.
module spi_reg_bridge #(
  parameter logic [7:0] STATUS_BYTE = 8'hA5,
  parameter logic [7:0] WRITE_FILL  = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ssel,
  input  logic             byte_received,
  input  logic [7:0]       received_data,
  input  logic             data_needed,
  output logic [7:0]       data_to_send,
  output logic             frame_active,
  output logic [7:0]       byte_count,
  spi_reg_bridge_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WRITE,
    S_RD_ISSUE,
    S_RD_CAPTURE,
    S_READ
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [6:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_tx;
  logic [7:0] r_cnt;
  logic       r_we;
  logic       w_re;
  logic       w_rx;
  logic       w_cmd_rx;
  logic       w_wr_rx;
  logic       w_unused;

  // Transmit loading is paced by byte_received alone.
  assign w_unused = data_needed;

  assign w_rx     = byte_received & ~ssel;
  assign w_cmd_rx = w_rx & (r_state == S_CMD);
  assign w_wr_rx  = w_rx & (r_state == S_WRITE);

  always_comb begin
    w_next = r_state;
    w_re   = 1'b0;
    if (r_state == S_RD_ISSUE) w_re = 1'b1;
    if (ssel) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:       w_next = S_CMD;
        S_CMD: begin
          if (w_rx)
            w_next = received_data[7] ? S_RD_ISSUE : S_WRITE;
        end
        S_WRITE:      w_next = S_WRITE;
        S_RD_ISSUE:   w_next = S_RD_CAPTURE;
        S_RD_CAPTURE: w_next = S_READ;
        S_READ: begin
          if (w_rx) w_next = S_RD_ISSUE;
        end
        default:      w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_tx    <= STATUS_BYTE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_we    <= w_wr_rx;
      if (w_wr_rx) r_wdata <= received_data;

      // Address steps the clk after each write strobe or read capture.
      if (w_cmd_rx)
        r_addr <= received_data[6:0];
      else if (r_we || (r_state == S_RD_CAPTURE && !ssel))
        r_addr <= r_addr + 7'd1;

      if (ssel)
        r_tx <= STATUS_BYTE;
      else if (w_cmd_rx && !received_data[7])
        r_tx <= WRITE_FILL;
      else if (r_state == S_RD_CAPTURE)
        r_tx <= bus.reg_rdata;

      if (ssel)
        r_cnt <= '0;
      else if (w_rx && r_state != S_IDLE && r_cnt != 8'hFF)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  assign bus.reg_addr  = r_addr;
  assign bus.reg_wdata = r_wdata;
  assign bus.reg_we    = r_we;
  assign bus.reg_re    = w_re;
  assign data_to_send  = r_tx;
  assign frame_active  = (r_state != S_IDLE);
  assign byte_count    = r_cnt;

endmodule
